// File: rtl/bcd_xs3_seq_converter.sv
// Multi-digit BCD <-> excess-3 converter: one digit per clock, LSD first,
// with per-digit invalid flags and valid/ready handshakes on both sides.
module bcd_xs3_seq_converter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a word moves on a side only in a cycle where valid && ready
    // are both high at the rising edge; in_ready is high only in IDLE and
    // out_valid only in DONE, so accept and deliver never overlap.

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   word_q, word_d;
    logic                  mode_q, mode_d;
    logic [4*DIGITS-1:0]   result_q, result_d;
    logic [DIGITS-1:0]     mask_q, mask_d;

    // Returns {invalid, converted digit}; invalid digits map to 4'hF.
    function automatic logic [4:0] conv_digit(input logic mode, input logic [3:0] d);
        logic       ok;
        logic [3:0] r;
        if (!mode) begin
            ok = (d <= 4'd9);
            r  = d + 4'd3;
        end else begin
            ok = (d >= 4'd3) && (d <= 4'd12);
            r  = d - 4'd3;
        end
        return ok ? {1'b0, r} : {1'b1, 4'hF};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            word_q   <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            mask_q   <= mask_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        mode_d   = mode_q;
        result_d = result_q;
        mask_d   = mask_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    word_d   = in_data;
                    mode_d   = in_mode;
                    result_d = '0;
                    mask_d   = '0;
                    idx_d    = '0;
                    state_d  = S_CONV;
                end
            end
            S_CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        {mask_d[i], result_d[4*i +: 4]} = conv_digit(mode_q, word_q[4*i +: 4]);
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == S_IDLE);
        out_valid    = (state_q == S_DONE);
        out_data     = result_q;
        out_err_mask = mask_q;
        out_err      = |mask_q;
        dbg_state_o  = state_q;
    end

endmodule
